ppu_line_renderer: RTL and testbench

//  Writer side of the ping-pong scanline buffer read by the VGA scanout path.
//  On each line_start, renders one 512-pixel line of the 64x64 character map into the idle bank.
//  Per pixel it fetches the glyph index from char RAM, then 2-bit pixel data from glyph-data RAM,

---
 rtl/ppu_pkg.sv | 45 ++++
 rtl/ppu_render_pipe.sv | 66 ++++++
 rtl/ppu_line_renderer.sv | 158 +++++++++++++++
 tb/tb_ppu_line_renderer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared constants, types and pixel helpers for the PPU scanline renderer.
// Define PPU_LINE_RENDERER_PAL_EN to add the per-glyph palette stage.
package ppu_pkg;

  localparam int LINE_PIXELS = 512;
  localparam int GLYPH_W     = 8;
  localparam int GLYPH_H     = 8;
  localparam int MAP_COLS    = 64;

  localparam int CHAR_AW  = 12;
  localparam int GDATA_AW = 12;
  localparam int LINE_AW  = 10;
  localparam int PAL_AW   = 10;
  localparam int X_W      = 9;

`ifdef PPU_LINE_RENDERER_PAL_EN
  localparam int PIPE_DEPTH = 3;
`else
  localparam int PIPE_DEPTH = 2;
`endif

  typedef logic [7:0] rgb332_t;
  typedef logic [1:0] pix_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } render_state_t;

  // Leftmost pixel of a glyph byte lives in the MSB pair.
  function automatic pix_idx_t pix_select(input logic [7:0] pixels, input logic [1:0] sel);
    case (sel)
      2'd0:    pix_select = pixels[7:6];
      2'd1:    pix_select = pixels[5:4];
      2'd2:    pix_select = pixels[3:2];
      default: pix_select = pixels[1:0];
    endcase
  endfunction

  function automatic rgb332_t grey_ramp(input pix_idx_t idx);
    grey_ramp = {idx, idx, idx, idx};
  endfunction

endpackage

// File: rtl/ppu_render_pipe.sv
// Valid/x/glyph shift registers that follow each issued pixel through the RAM reads.
// With PPU_LINE_RENDERER_PAL_EN the pipe is one stage deeper and carries the glyph index.
module ppu_render_pipe
  import ppu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           i_issue,
  input  logic [X_W-1:0] i_x,
`ifdef PPU_LINE_RENDERER_PAL_EN
  input  logic [7:0]     i_glyph,
  output logic           o_v2,
  output logic [7:0]     o_glyph2,
`endif
  output logic           o_v1,
  output logic           o_x1_half,
  output logic [1:0]     o_x2_sel,
  output logic           o_vlast,
  output logic [X_W-1:0] o_xlast
);

  logic           r_valid [1:PIPE_DEPTH];
  logic [X_W-1:0] r_x     [1:PIPE_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid[1] <= 1'b0;
    end else begin
      r_valid[1] <= i_issue;
    end
    r_x[1] <= i_x;
  end

  genvar gi;
  generate
    for (gi = 2; gi <= PIPE_DEPTH; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid[gi] <= 1'b0;
        end else begin
          r_valid[gi] <= r_valid[gi-1];
        end
        r_x[gi] <= r_x[gi-1];
      end
    end
  endgenerate

`ifdef PPU_LINE_RENDERER_PAL_EN
  // Glyph index arrives from char RAM during stage 1 and is needed for the palette address.
  logic [7:0] r_glyph2;

  always_ff @(posedge clk) begin
    r_glyph2 <= i_glyph;
  end

  assign o_v2     = r_valid[2];
  assign o_glyph2 = r_glyph2;
`endif

  assign o_v1      = r_valid[1];
  assign o_x1_half = r_x[1][2];
  assign o_x2_sel  = r_x[2][1:0];
  assign o_vlast   = r_valid[PIPE_DEPTH];
  assign o_xlast   = r_x[PIPE_DEPTH];

endmodule

// File: rtl/ppu_line_renderer.sv
// Renders one 512-pixel line of the 64x64 character map into the idle line RAM bank.
// Define PPU_LINE_RENDERER_PAL_EN for per-glyph palettes instead of the grey ramp.
module ppu_line_renderer
  import ppu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                line_start,
  input  logic [8:0]          line_y,
  input  logic                bank,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic [CHAR_AW-1:0]  char_addr,
  input  logic [7:0]          char_data,
  output logic [GDATA_AW-1:0] gdata_addr,
  input  logic [7:0]          gdata_data,
`ifdef PPU_LINE_RENDERER_PAL_EN
  output logic [PAL_AW-1:0]   pal_addr,
  input  logic [7:0]          pal_data,
`endif
  output logic                line_we,
  output logic [LINE_AW-1:0]  line_addr,
  output logic [7:0]          line_wdata
);

  localparam logic [X_W-1:0] X_LAST = X_W'(LINE_PIXELS - 1);

  render_state_t      r_state;
  logic [X_W-1:0]     r_x;
  logic [8:0]         r_y_l;
  logic               r_bank_l;
  logic               r_busy;
  logic               r_done;
  logic               r_overrun;
  logic               r_line_we;
  logic [LINE_AW-1:0] r_line_addr;
  rgb332_t            r_line_wdata;

  logic               w_issue;
  logic               w_accept;
  logic               w_v1;
  logic               w_x1_half;
  logic [1:0]         w_x2_sel;
  logic               w_vlast;
  logic [X_W-1:0]     w_xlast;
  pix_idx_t           w_idx;
  rgb332_t            w_colour;

  assign w_issue = (r_state == FETCH);
  // r_done is only ever high in the last DRAIN cycle, so a start there chains lines.
  assign w_accept = line_start && ((r_state == IDLE) || r_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_x       <= '0;
      r_y_l     <= '0;
      r_bank_l  <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= line_start && !w_accept;
      if (w_accept) begin
        r_state  <= FETCH;
        r_x      <= '0;
        r_y_l    <= line_y;
        r_bank_l <= bank;
        r_busy   <= 1'b1;
      end else begin
        case (r_state)
          FETCH: begin
            if (r_x == X_LAST) begin
              r_state <= DRAIN;
              r_x     <= '0;
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
          DRAIN: begin
            if (r_done) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef PPU_LINE_RENDERER_PAL_EN
  logic       w_v2;
  logic [7:0] w_glyph2;

  ppu_render_pipe u_pipe (
    .clk       (clk),
    .rst       (rst),
    .i_issue   (w_issue),
    .i_x       (r_x),
    .i_glyph   (char_data),
    .o_v2      (w_v2),
    .o_glyph2  (w_glyph2),
    .o_v1      (w_v1),
    .o_x1_half (w_x1_half),
    .o_x2_sel  (w_x2_sel),
    .o_vlast   (w_vlast),
    .o_xlast   (w_xlast)
  );

  assign pal_addr = w_v2 ? {w_glyph2, w_idx} : '0;
  assign w_colour = pal_data;
`else
  ppu_render_pipe u_pipe (
    .clk       (clk),
    .rst       (rst),
    .i_issue   (w_issue),
    .i_x       (r_x),
    .o_v1      (w_v1),
    .o_x1_half (w_x1_half),
    .o_x2_sel  (w_x2_sel),
    .o_vlast   (w_vlast),
    .o_xlast   (w_xlast)
  );

  assign w_colour = grey_ramp(w_idx);
`endif

  assign char_addr  = w_issue ? {r_y_l[8:3], r_x[8:3]} : '0;
  assign gdata_addr = w_v1 ? {char_data, r_y_l[2:0], w_x1_half} : '0;
  assign w_idx      = pix_select(gdata_data, w_x2_sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line_we    <= 1'b0;
      r_line_addr  <= '0;
      r_line_wdata <= '0;
      r_done       <= 1'b0;
    end else begin
      r_line_we <= w_vlast;
      if (w_vlast) begin
        r_line_addr  <= {r_bank_l, w_xlast};
        r_line_wdata <= w_colour;
      end
      r_done <= r_line_we && (r_line_addr[X_W-1:0] == X_LAST);
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign overrun    = r_overrun;
  assign line_we    = r_line_we;
  assign line_addr  = r_line_addr;
  assign line_wdata = r_line_wdata;

endmodule

// File: tb/tb_ppu_line_renderer.sv
// Directed bench for ppu_line_renderer: bench-side RAM models, write/done/overrun monitor.
// Builds with or without PPU_LINE_RENDERER_PAL_EN.
`timescale 1ns/1ps
module tb_ppu_line_renderer;
  import ppu_pkg::*;

`ifdef PPU_LINE_RENDERER_PAL_EN
  localparam int WR_OFS = 5;
`else
  localparam int WR_OFS = 4;
`endif
  localparam int DONE_OFS = WR_OFS + LINE_PIXELS;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [8:0]  line_y;
  logic        bank;
  logic        busy, done, overrun;
  logic [11:0] char_addr;
  logic [7:0]  char_data;
  logic [11:0] gdata_addr;
  logic [7:0]  gdata_data;
  logic        line_we;
  logic [9:0]  line_addr;
  logic [7:0]  line_wdata;
`ifdef PPU_LINE_RENDERER_PAL_EN
  logic [9:0]  pal_addr;
  logic [7:0]  pal_data;
`endif

  ppu_line_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .line_start (line_start),
    .line_y     (line_y),
    .bank       (bank),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .char_addr  (char_addr),
    .char_data  (char_data),
    .gdata_addr (gdata_addr),
    .gdata_data (gdata_data),
`ifdef PPU_LINE_RENDERER_PAL_EN
    .pal_addr   (pal_addr),
    .pal_data   (pal_data),
`endif
    .line_we    (line_we),
    .line_addr  (line_addr),
    .line_wdata (line_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int ram_mode = 0;

  function automatic logic [7:0] char_f(input logic [11:0] a);
    if (ram_mode == 0) return 8'h01;
    return a[7:0] ^ {a[11:6], 2'b10};
  endfunction

  function automatic logic [7:0] gdata_f(input logic [11:0] a);
    if (ram_mode == 0) return 8'hE4;
    return a[7:0] ^ {a[3:0], a[11:8]} ^ 8'h5A;
  endfunction

  // Synchronous-read RAM models, one cycle of latency.
  always @(posedge clk) begin
    char_data  <= char_f(char_addr);
    gdata_data <= gdata_f(gdata_addr);
`ifdef PPU_LINE_RENDERER_PAL_EN
    pal_data   <= pal_addr[7:0];
`endif
  end

  // Reference pixel built from map geometry arithmetic; 0xE4 renders FF,AA,55,00 (MSB pair leftmost).
  function automatic logic [7:0] exp_pixel(input int y, input int x);
    logic [11:0] ca, ga;
    logic [7:0]  g, pix;
    int          idx;
    ca  = 12'((y / 8) * 64 + x / 8);
    g   = char_f(ca);
    ga  = 12'(int'(g) * 16 + (y % 8) * 2 + (x % 8) / 4);
    pix = gdata_f(ga);
    idx = (int'(pix) >> (2 * (3 - x % 4))) & 3;
`ifdef PPU_LINE_RENDERER_PAL_EN
    return {g[5:0], 2'(idx)};
`else
    return 8'(idx * 85);
`endif
  endfunction

  typedef struct {
    int         cyc;
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];
  int  ov_q[$];
  int  busy_low = 0;
  bit  watch_busy = 1'b0;

  always @(negedge clk) begin
    if (line_we === 1'b1) wr_q.push_back('{cyc, line_addr, line_wdata});
    if (done === 1'b1) done_q.push_back(cyc);
    if (overrun === 1'b1) ov_q.push_back(cyc);
    if (watch_busy && busy !== 1'b1) busy_low++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic start_line(input int y, input logic b, output int s);
    line_y     = 9'(y);
    bank       = b;
    line_start = 1'b1;
    s          = cyc;
    step();
    line_start = 1'b0;
    line_y     = 9'h1A5;
    bank       = ~b;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      step();
      n++;
    end
    check_eq({tag, "_idle"}, 64'(busy), 64'd0);
    repeat (3) step();
  endtask

  task automatic check_line(input string tag, input int s, input int y, input logic b, input int n);
    wr_t         w;
    logic [63:0] got, exp;
    for (int x = 0; x < n; x++) begin
      if (wr_q.size() == 0) break;
      w   = wr_q.pop_front();
      got = {32'(w.cyc - s), 14'd0, w.addr, w.data};
      exp = {32'(x + WR_OFS), 14'd0, b, 9'(x), exp_pixel(y, x)};
      check_eq($sformatf("%s_px%0d", tag, x), got, exp);
    end
    $display("line y=%0d bank=%0d start=%0d: %0d pixels checked", y, b, s, n);
  endtask

  task automatic clear_mon();
    wr_q.delete();
    done_q.delete();
    ov_q.delete();
  endtask

  initial begin
    int s, s2, d;
    rst        = 1'b1;
    line_start = 1'b0;
    line_y     = '0;
    bank       = 1'b0;
    repeat (3) step();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_overrun", 64'(overrun), 64'd0);
    check_eq("rst_line_we", 64'(line_we), 64'd0);
    check_eq("rst_char_addr", 64'(char_addr), 64'd0);
    check_eq("rst_gdata_addr", 64'(gdata_addr), 64'd0);
    check_eq("rst_line_addr", 64'(line_addr), 64'd0);
    check_eq("rst_line_wdata", 64'(line_wdata), 64'd0);
    rst = 1'b0;
    step();

    // Constant RAMs, bank 1.
    ram_mode = 0;
    clear_mon();
    start_line(0, 1'b1, s);
    wait_idle("t1");
    check_eq("t1_count", 64'(wr_q.size()), 64'd512);
    check_line("t1", s, 0, 1'b1, 512);
    check_eq("t1_done_n", 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0) check_eq("t1_done_cyc", 64'(done_q[0] - s), 64'(DONE_OFS));
    check_eq("t1_overrun_n", 64'(ov_q.size()), 64'd0);

    // Address-dependent RAMs; row field and glyph row spot checks.
    ram_mode = 1;
    clear_mon();
    start_line(13, 1'b0, s);
    wait_until(s + 1);
    check_eq("t2_char_addr_x0", 64'(char_addr), 64'h040);
    wait_until(s + 2);
    check_eq("t2_gdata_addr_x0", 64'(gdata_addr), 64'({char_f(12'h040), 3'd5, 1'b0}));
    wait_until(s + 1 + 77);
    check_eq("t2_char_addr_x77", 64'(char_addr), 64'h049);
    wait_until(s + 2 + 77);
    check_eq("t2_gdata_addr_x77", 64'(gdata_addr), 64'({char_f(12'h049), 3'd5, 1'b1}));
    wait_idle("t2");
    check_eq("t2_count", 64'(wr_q.size()), 64'd512);
    check_line("t2", s, 13, 1'b0, 512);
    check_eq("t2_done_n", 64'(done_q.size()), 64'd1);

    // Start while busy is dropped and flagged once.
    clear_mon();
    start_line(200, 1'b1, s);
    wait_until(s + 100);
    start_line(7, 1'b0, s2);
    wait_idle("t3");
    check_eq("t3_overrun_n", 64'(ov_q.size()), 64'd1);
    if (ov_q.size() > 0) begin
      d = ov_q[0] - s;
      check_eq("t3_overrun_cyc", 64'(d == 100 || d == 101), 64'd1);
    end
    check_eq("t3_count", 64'(wr_q.size()), 64'd512);
    check_line("t3", s, 200, 1'b1, 512);
    check_eq("t3_done_n", 64'(done_q.size()), 64'd1);

    // Start on the done cycle chains two lines with busy held.
    clear_mon();
    busy_low = 0;
    start_line(345, 1'b0, s);
    watch_busy = 1'b1;
    wait_until(s + DONE_OFS);
    check_eq("t4_done_at_chain", 64'(done), 64'd1);
    start_line(346, 1'b1, s2);
    wait_until(s2 + DONE_OFS);
    watch_busy = 1'b0;
    wait_idle("t4");
    check_eq("t4_busy_low", 64'(busy_low), 64'd0);
    check_eq("t4_count", 64'(wr_q.size()), 64'd1024);
    check_line("t4a", s, 345, 1'b0, 512);
    check_line("t4b", s2, 346, 1'b1, 512);
    check_eq("t4_done_n", 64'(done_q.size()), 64'd2);
    if (done_q.size() > 1) begin
      check_eq("t4_done0_cyc", 64'(done_q[0] - s), 64'(DONE_OFS));
      check_eq("t4_done1_cyc", 64'(done_q[1] - s), 64'(2 * DONE_OFS));
    end
    check_eq("t4_overrun_n", 64'(ov_q.size()), 64'd0);

    // Reset mid-line, then a normal line at the bottom row.
    clear_mon();
    start_line(100, 1'b1, s);
    wait_until(s + 200);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t5_we_after_rst", 64'(line_we), 64'd0);
    check_eq("t5_busy_after_rst", 64'(busy), 64'd0);
    repeat (700) step();
    check_eq("t5_count", 64'(wr_q.size()), 64'(200 - WR_OFS + 1));
    check_line("t5", s, 100, 1'b1, 200 - WR_OFS + 1);
    check_eq("t5_done_n", 64'(done_q.size()), 64'd0);
    clear_mon();
    start_line(511, 1'b0, s);
    wait_idle("t5r");
    check_eq("t5r_count", 64'(wr_q.size()), 64'd512);
    check_line("t5r", s, 511, 1'b0, 512);
    check_eq("t5r_done_n", 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0) check_eq("t5r_done_cyc", 64'(done_q[0] - s), 64'(DONE_OFS));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
